// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared widths and write-request type for the register file
// Revision    : 1.0
// ============================================================================
package regfile_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_wr_slot.sv
`default_nettype none
// ============================================================================
// wr_slot : one-entry holding register with full flag and same-edge refill
// Revision: 1.0
// ============================================================================
module wr_slot
    import regfile_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  logic    drain,
    input  wr_req_t in_req,
    output logic    full,
    output logic    ready,
    output wr_req_t entry
);
    // A load on the same edge as a drain wins, keeping the slot full.
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= in_req;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

    assign ready = !full || drain;
endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter : round-robin / oldest-first sharing of the RF write port
// Revision             : 1.0
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              grant_id,
    output logic [NREGS-1:0]  pending
);
    wr_req_t slot0, slot1, granted;
    logic    full0, full1;
    logic    load0, load1, drain0, drain1;
    logic    grant_valid, grant;
    logic    rr, age;   // age = 1 : slot 0 holds the older entry

    assign load0 = req0_valid && req0_ready;
    assign load1 = req1_valid && req1_ready;

    wr_slot u_slot0 (
        .clk    (clk),
        .reset  (reset),
        .load   (load0),
        .drain  (drain0),
        .in_req ('{rd: req0_reg, data: req0_data}),
        .full   (full0),
        .ready  (req0_ready),
        .entry  (slot0)
    );

    wr_slot u_slot1 (
        .clk    (clk),
        .reset  (reset),
        .load   (load1),
        .drain  (drain1),
        .in_req ('{rd: req1_reg, data: req1_data}),
        .full   (full1),
        .ready  (req1_ready),
        .entry  (slot1)
    );

    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (full0 && full1) begin
            grant_valid = 1'b1;
            grant       = (slot0.rd == slot1.rd) ? !age : rr;
        end else if (full0) begin
            grant_valid = 1'b1;
        end else if (full1) begin
            grant_valid = 1'b1;
            grant       = 1'b1;
        end
    end

    assign drain0  = grant_valid && !grant;
    assign drain1  = grant_valid && grant;
    assign granted = grant ? slot1 : slot0;

    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            grant_id     <= 1'b0;
            rr           <= 1'b0;
            age          <= 1'b0;
        end else begin
            write_enable <= grant_valid;
            if (grant_valid) begin
                write_reg  <= granted.rd;
                write_data <= granted.data;
                grant_id   <= grant;
                rr         <= !grant;
            end
            // A new entry is younger than one that stays resident.
            if (load0 && load1)
                age <= 1'b1;
            else if (load0 && full1 && !drain1)
                age <= 1'b0;
            else if (load1 && full0 && !drain0)
                age <= 1'b1;
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_pending
        assign pending[r] = (full0 && slot0.rd == ADDR_W'(r)) ||
                            (full1 && slot1.rd == ADDR_W'(r)) ||
                            (write_enable && write_reg == ADDR_W'(r));
    end
endmodule
`default_nettype wire
